// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Unified memory port arbiter between fetch (I) and load/store (D).
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 2,
   parameter int CNT_W        = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_READ,
   input  logic [31:0] I_ADDR,
   input  logic        D_READ,
   input  logic        D_WRITE,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WRITEDATA,
   input  logic        MEM_READY,
   input  logic [31:0] MEM_READDATA,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic        SELECT,
   output logic        I_BUSYWAIT,
   output logic        D_BUSYWAIT,
   output logic [31:0] I_READDATA,
   output logic [31:0] D_READDATA
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_D = 3'd2,
      DONE_I  = 3'd3,
      DONE_D  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             d_req;
   logic             d_wins;

   // Addresses and write data reach memory through external muxes steered by SELECT.
   logic unused_mux_inputs;
   assign unused_mux_inputs = ^{I_ADDR, D_ADDR, D_WRITEDATA};

   assign d_req  = D_READ | D_WRITE;
   assign d_wins = d_req & (!I_READ | (starve_cnt < LIMIT));

   assign I_BUSYWAIT = I_READ & (state != DONE_I);
   assign D_BUSYWAIT = d_req  & (state != DONE_D);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         MEM_READ   <= 1'b0;
         MEM_WRITE  <= 1'b0;
         SELECT     <= 1'b0;
         starve_cnt <= '0;
         I_READDATA <= '0;
         D_READDATA <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_wins) begin
                  state     <= GRANT_D;
                  SELECT    <= 1'b1;
                  MEM_WRITE <= D_WRITE;
                  MEM_READ  <= D_READ & !D_WRITE;
                  if (!I_READ)
                     starve_cnt <= '0;
                  else if (starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + 1'b1;
               end else if (I_READ) begin
                  state      <= GRANT_I;
                  SELECT     <= 1'b0;
                  MEM_READ   <= 1'b1;
                  MEM_WRITE  <= 1'b0;
                  starve_cnt <= '0;
               end
            end
            GRANT_I: begin
               if (MEM_READY) begin
                  state      <= DONE_I;
                  MEM_READ   <= 1'b0;
                  I_READDATA <= MEM_READDATA;
               end
            end
            GRANT_D: begin
               // Strobes were captured at grant, so a withdrawn load still latches its data.
               if (MEM_READY) begin
                  state     <= DONE_D;
                  MEM_READ  <= 1'b0;
                  MEM_WRITE <= 1'b0;
                  if (MEM_READ)
                     D_READDATA <= MEM_READDATA;
               end
            end
            DONE_I, DONE_D: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        I_READ;
   logic [31:0] I_ADDR;
   logic        D_READ;
   logic        D_WRITE;
   logic [31:0] D_ADDR;
   logic [31:0] D_WRITEDATA;
   logic        MEM_READY;
   logic [31:0] MEM_READDATA;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic        SELECT;
   logic        I_BUSYWAIT;
   logic        D_BUSYWAIT;
   logic [31:0] I_READDATA;
   logic [31:0] D_READDATA;

   int n_cmp = 0;
   int n_err = 0;

   localparam int S_IDLE = 0, S_GRANT_I = 1, S_GRANT_D = 2, S_DONE_I = 3, S_DONE_D = 4;

   mem_port_arbiter #(.STARVE_LIMIT(2), .CNT_W(2)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDR(I_ADDR),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
      .MEM_READY(MEM_READY), .MEM_READDATA(MEM_READDATA),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .SELECT(SELECT),
      .I_BUSYWAIT(I_BUSYWAIT), .D_BUSYWAIT(D_BUSYWAIT),
      .I_READDATA(I_READDATA), .D_READDATA(D_READDATA)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d_rd;
      logic        exp_sel;

      RESET = 1'b1; I_READ = 0; I_ADDR = 0; D_READ = 0; D_WRITE = 0;
      D_ADDR = 0; D_WRITEDATA = 0; MEM_READY = 0; MEM_READDATA = 0;
      repeat (2) tick();
      chk("rst_mem_read", 32'(MEM_READ), 0);
      chk("rst_mem_write", 32'(MEM_WRITE), 0);
      chk("rst_select", 32'(SELECT), 0);
      chk("rst_i_rdata", I_READDATA, 0);
      chk("rst_d_rdata", D_READDATA, 0);
      chk("rst_state", 32'(dut.state), S_IDLE);
      RESET = 1'b0;

      // 1: single fetch, MEM_READY in cycle 3
      I_READ = 1; I_ADDR = 32'h100;
      tick();
      chk("t1_c1_read", 32'(MEM_READ), 1);
      chk("t1_c1_sel", 32'(SELECT), 0);
      chk("t1_c1_ibusy", 32'(I_BUSYWAIT), 1);
      tick();
      chk("t1_c2_read", 32'(MEM_READ), 1);
      chk("t1_c2_ibusy", 32'(I_BUSYWAIT), 1);
      tick();
      chk("t1_c3_read", 32'(MEM_READ), 1);
      chk("t1_c3_ibusy", 32'(I_BUSYWAIT), 1);
      MEM_READY = 1; MEM_READDATA = 32'h00A00093;
      tick();
      chk("t1_c4_ibusy", 32'(I_BUSYWAIT), 0);
      chk("t1_c4_rdata", I_READDATA, 32'h00A00093);
      chk("t1_c4_read", 32'(MEM_READ), 0);
      chk("t1_c4_sel", 32'(SELECT), 0);
      MEM_READY = 0; I_READ = 0;
      tick();
      chk("t1_c5_state", 32'(dut.state), S_IDLE);

      // 2: simultaneous I and D, D first
      I_READ = 1; I_ADDR = 32'h104; D_READ = 1; D_ADDR = 32'h2000;
      tick();
      chk("t2_d_sel", 32'(SELECT), 1);
      chk("t2_d_read", 32'(MEM_READ), 1);
      chk("t2_d_dbusy", 32'(D_BUSYWAIT), 1);
      chk("t2_d_ibusy", 32'(I_BUSYWAIT), 1);
      tick();
      MEM_READY = 1; MEM_READDATA = 32'hD0D00001;
      tick();
      chk("t2_doned_dbusy", 32'(D_BUSYWAIT), 0);
      chk("t2_doned_ibusy", 32'(I_BUSYWAIT), 1);
      chk("t2_doned_rdata", D_READDATA, 32'hD0D00001);
      MEM_READY = 0; D_READ = 0;
      tick();
      chk("t2_idle_state", 32'(dut.state), S_IDLE);
      tick();
      chk("t2_i_sel", 32'(SELECT), 0);
      chk("t2_i_read", 32'(MEM_READ), 1);
      tick();
      MEM_READY = 1; MEM_READDATA = 32'h11110002;
      tick();
      chk("t2_donei_ibusy", 32'(I_BUSYWAIT), 0);
      chk("t2_donei_rdata", I_READDATA, 32'h11110002);
      MEM_READY = 0; I_READ = 0;
      tick();

      // 3: starvation bound, grant order D D I D D I
      I_READ = 1; D_READ = 1; D_ADDR = 32'h3000;
      d_rd = D_READDATA;
      for (int k = 0; k < 6; k++) begin
         exp_sel = (k % 3 == 2) ? 1'b0 : 1'b1;
         tick();
         chk($sformatf("t3_g%0d_sel", k), 32'(SELECT), 32'(exp_sel));
         chk($sformatf("t3_g%0d_read", k), 32'(MEM_READ), 1);
         MEM_READY = 1; MEM_READDATA = 32'hC0DE0000 + 32'(k);
         tick();
         MEM_READY = 0;
         if (exp_sel) begin
            d_rd = 32'hC0DE0000 + 32'(k);
            chk($sformatf("t3_g%0d_dbusy", k), 32'(D_BUSYWAIT), 0);
            chk($sformatf("t3_g%0d_drd", k), D_READDATA, d_rd);
         end else begin
            chk($sformatf("t3_g%0d_ibusy", k), 32'(I_BUSYWAIT), 0);
            chk($sformatf("t3_g%0d_cnt", k), 32'(dut.starve_cnt), 0);
         end
         if (k == 5) begin
            I_READ = 0; D_READ = 0;
         end
         tick();
      end

      // 4: illegal read+write, write wins
      D_READ = 1; D_WRITE = 1; D_WRITEDATA = 32'hDEADBEEF; D_ADDR = 32'h40;
      tick();
      chk("t4_write", 32'(MEM_WRITE), 1);
      chk("t4_read", 32'(MEM_READ), 0);
      chk("t4_sel", 32'(SELECT), 1);
      MEM_READY = 1; MEM_READDATA = 32'hBADBAD00;
      tick();
      MEM_READY = 0;
      chk("t4_done_write", 32'(MEM_WRITE), 0);
      chk("t4_done_drd", D_READDATA, d_rd);
      chk("t4_done_dbusy", 32'(D_BUSYWAIT), 0);
      D_READ = 0; D_WRITE = 0;
      tick();

      // 5: reset during GRANT_D
      D_READ = 1; D_ADDR = 32'h44;
      tick();
      chk("t5_g_read", 32'(MEM_READ), 1);
      chk("t5_g_sel", 32'(SELECT), 1);
      RESET = 1; D_READ = 0;
      tick();
      chk("t5_r_read", 32'(MEM_READ), 0);
      chk("t5_r_write", 32'(MEM_WRITE), 0);
      chk("t5_r_sel", 32'(SELECT), 0);
      chk("t5_r_drd", D_READDATA, 0);
      chk("t5_r_ird", I_READDATA, 0);
      chk("t5_r_state", 32'(dut.state), S_IDLE);
      RESET = 0; I_READ = 1; I_ADDR = 32'h200;
      tick();
      chk("t5_i_read", 32'(MEM_READ), 1);
      MEM_READY = 1; MEM_READDATA = 32'h00000013;
      tick();
      chk("t5_i_ibusy", 32'(I_BUSYWAIT), 0);
      chk("t5_i_rdata", I_READDATA, 32'h00000013);
      MEM_READY = 0; I_READ = 0;
      tick();

      // 6: D withdraws mid-grant, I pending, stray MEM_READY in IDLE
      D_READ = 1; D_ADDR = 32'h2040; I_READ = 1; I_ADDR = 32'h300;
      tick();
      chk("t6_c1_state", 32'(dut.state), S_GRANT_D);
      tick();
      D_READ = 0;
      tick();
      chk("t6_c3_read", 32'(MEM_READ), 1);
      MEM_READY = 1; MEM_READDATA = 32'h12345678;
      tick();
      chk("t6_c4_state", 32'(dut.state), S_DONE_D);
      chk("t6_c4_drd", D_READDATA, 32'h12345678);
      chk("t6_c4_dbusy", 32'(D_BUSYWAIT), 0);
      MEM_READY = 0;
      tick();
      chk("t6_c5_state", 32'(dut.state), S_IDLE);
      MEM_READY = 1; MEM_READDATA = 32'hFFFF0000;
      tick();
      chk("t6_c6_state", 32'(dut.state), S_GRANT_I);
      chk("t6_c6_sel", 32'(SELECT), 0);
      chk("t6_c6_ird", I_READDATA, 32'h00000013);
      MEM_READY = 1; MEM_READDATA = 32'h00000297;
      tick();
      chk("t6_c7_state", 32'(dut.state), S_DONE_I);
      chk("t6_c7_ird", I_READDATA, 32'h00000297);
      MEM_READY = 0; I_READ = 0;
      tick();
      chk("t6_c8_state", 32'(dut.state), S_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (requester I) and the MEM-stage load/store unit (requester D).
- Sequences one memory transaction at a time.
- Drives the SELECT line of the 32-bit 2-to-1 address and write-data muxes (IN0 = I side, IN1 = D side).
- Stalls the losing requester via its BUSYWAIT.
- Data side has priority; a bounded starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 2, max consecutive D grants issued while I_READ is pending before I is forced to win.
- CNT_W, 2, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- I_READ  input  1  fetch read request, held until I_BUSYWAIT low.
- I_ADDR  input  32  fetch address, stable while requesting.
- D_READ  input  1  load request.
- D_WRITE  input  1  store request.
- D_ADDR  input  32  load/store address.
- D_WRITEDATA  input  32  store data.
- MEM_READY  input  1  one-cycle pulse from memory: transaction complete.
- MEM_READDATA  input  32  read data, valid when MEM_READY=1.
- MEM_READ  output  1  memory read strobe.
- MEM_WRITE  output  1  memory write strobe.
- SELECT  output  1  mux select: 0 = I, 1 = D; feeds the address and write-data muxes.
- I_BUSYWAIT  output  1  stall fetch.
- D_BUSYWAIT  output  1  stall MEM stage.
- I_READDATA  output  32  registered fetch data.
- D_READDATA  output  32  registered load data.

Behaviour:
- Reset (CLK edge with RESET=1): state IDLE; MEM_READ=MEM_WRITE=0; SELECT=0; starve_cnt=0; I_READDATA=D_READDATA=0. Reset mid-transaction abandons it; no DONE state is entered.
- States: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D. All state, SELECT and strobes are registered.
- D_REQ = D_READ | D_WRITE.
- IDLE transitions:
  - D_REQ and (!I_READ or starve_cnt < STARVE_LIMIT) -> GRANT_D.
  - Else I_READ -> GRANT_I.
  - Else stay in IDLE.
- GRANT_D entry: if I_READ, starve_cnt++ (saturating); else starve_cnt=0.
- GRANT_I entry: starve_cnt=0.
- GRANT_x outputs: SELECT = (x==D).
  - GRANT_I: MEM_READ=1.
  - GRANT_D: MEM_WRITE=D_WRITE; MEM_READ=D_READ & !D_WRITE.
  - Address/write-data reach memory through the muxes combinationally; requesters hold them stable.
- GRANT_x exit: stay until MEM_READY=1. On that edge, latch MEM_READDATA into x_READDATA (reads only; stores leave D_READDATA unchanged) and go to DONE_x.
- DONE_x: strobes 0, SELECT held; lasts exactly one cycle, then IDLE.
- BUSYWAIT: I_BUSYWAIT = I_READ & (state != DONE_I); D_BUSYWAIT = D_REQ & (state != DONE_D). Combinational from registered state.
- The requester samples x_READDATA at the edge ending DONE_x.
- Latency: request seen in IDLE at cycle 0 -> strobe in cycle 1 -> with MEM_READY in cycle k, BUSYWAIT low in cycle k+1. Minimum 2 cycles.
- Simultaneous I and D requests: D wins unless starve_cnt == STARVE_LIMIT.
- Back-to-back: every transaction passes through IDLE; no consecutive grants without an IDLE cycle.
- Withdrawal (flush) while in GRANT_x: transaction still completes and data is latched; DONE_x occurs; BUSYWAIT is already 0 because the request is 0.
- D_READ & D_WRITE both 1 (illegal): write wins, MEM_READ=0.
- MEM_READY in IDLE/DONE: ignored.

Test Plan:
1. I_READ=1, I_ADDR=0x100; MEM_READY with 0x00A00093 in cycle 3 -> MEM_READ=1, SELECT=0 in cycles 1-3; I_READDATA=0x00A00093; I_BUSYWAIT low only in cycle 4.
2. I_READ and D_READ (D_ADDR=0x2000) asserted together, each memory response 2 cycles -> D served first (SELECT=1), then I. Grant order D, I; D_BUSYWAIT drops before I_BUSYWAIT.
3. STARVE_LIMIT=2, D requests continuously, I_READ held -> grant order D, D, I, D, D, I; starve_cnt returns to 0 after each I grant.
4. D_WRITE=D_READ=1, D_WRITEDATA=0xDEADBEEF, D_ADDR=0x40 -> MEM_WRITE=1, MEM_READ=0, SELECT=1, D_READDATA unchanged after completion.
5. RESET pulsed while in GRANT_D with MEM_READ=1 -> next cycle all outputs 0, IDLE. A new I_READ afterward completes normally with 2-cycle minimum latency.
6. D_READ dropped in cycle 2 of GRANT_D; MEM_READY with 0x12345678 in cycle 3 -> D_READDATA=0x12345678, one DONE_D cycle, IDLE; pending I granted next.
